// File: rtl/umstr_chan_packer.sv
// umstr_chan_packer: tags a user stream with per-channel destination and
// global source addressing. The header is looked up on the SOP beat and held
// until that packet's tlast. Packets on disabled channels are consumed and
// counted as drops. Two-stage pipeline, one beat per clock.
module umstr_chan_packer #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [47:0]           cntrl_mac_src_i,
  input  logic [31:0]           cntrl_ip_src_i,
  input  logic [15:0]           cntrl_port_src_i,
  input  logic [ID_WIDTH-1:0]   cntrl_addr_cell_dest_i,
  input  logic [47:0]           cntrl_mac_dest_i,
  input  logic [31:0]           cntrl_ip_dest_i,
  input  logic [15:0]           cntrl_port_dest_i,
  input  logic                  cntrl_chan_en_i,
  input  logic [3:0]            cntrl_cell_dest_wr_i,
  output logic [47:0]           cntrl_mac_dest_rdata_o,
  output logic [31:0]           cntrl_ip_dest_rdata_o,
  output logic [15:0]           cntrl_port_dest_rdata_o,
  output logic                  cntrl_chan_en_rdata_o,
  input  logic                  stat_clr_i,
  output logic [31:0]           stat_tx_pkt_o,
  output logic [31:0]           stat_drop_pkt_o,
  input  logic [ID_WIDTH-1:0]   user_in_tid_i,
  input  logic [DATA_WIDTH-1:0] user_in_tdata_i,
  input  logic [KEEP_WIDTH-1:0] user_in_tkeep_i,
  input  logic                  user_in_tvld_i,
  input  logic                  user_in_tlast_i,
  output logic                  user_in_trdy_o,
  output logic [47:0]           hdr_mac_dest_o,
  output logic [47:0]           hdr_mac_src_o,
  output logic [31:0]           hdr_ip_dest_o,
  output logic [31:0]           hdr_ip_src_o,
  output logic [15:0]           hdr_port_dest_o,
  output logic [15:0]           hdr_port_src_o,
  output logic [ID_WIDTH-1:0]   hdr_tid_o,
  output logic [DATA_WIDTH-1:0] user_out_tdata_o,
  output logic [KEEP_WIDTH-1:0] user_out_tkeep_o,
  output logic                  user_out_tvld_o,
  output logic                  user_out_tlast_o,
  input  logic                  user_out_rdy_i
);

  localparam int NCH = 2 ** ID_WIDTH;

  // destination tables (not reset; software fills them before enabling)
  logic [47:0] mac_ram  [NCH];
  logic [31:0] ip_ram   [NCH];
  logic [15:0] port_ram [NCH];
  logic [NCH-1:0] en_reg;
  logic [NCH-1:0] en_wr_sel;

  // pipeline-side table read results, aligned with stage 1
  logic [47:0] mac_q_reg;
  logic [31:0] ip_q_reg;
  logic [15:0] port_q_reg;
  logic        en_q_reg;

  // control readback registers
  logic [47:0] mac_rd_reg;
  logic [31:0] ip_rd_reg;
  logic [15:0] port_rd_reg;
  logic        en_rd_reg;

  // stage 1
  logic                  s1_vld_reg;
  logic                  s1_sop_reg;
  logic                  s1_last_reg;
  logic [ID_WIDTH-1:0]   s1_tid_reg;
  logic [DATA_WIDTH-1:0] s1_data_reg;
  logic [KEEP_WIDTH-1:0] s1_keep_reg;

  // input-side SOP tracking and packet drop state
  logic sop_reg;
  logic drop_reg;

  // stage 2 (output)
  logic                  out_vld_reg;
  logic                  out_last_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic [KEEP_WIDTH-1:0] out_keep_reg;
  logic [47:0]           hdr_mac_dest_reg, hdr_mac_src_reg;
  logic [31:0]           hdr_ip_dest_reg, hdr_ip_src_reg;
  logic [15:0]           hdr_port_dest_reg, hdr_port_src_reg;
  logic [ID_WIDTH-1:0]   hdr_tid_reg;

  logic [31:0] tx_cnt_reg;
  logic [31:0] drop_cnt_reg;

  logic                rdy;
  logic                accept;
  logic                xfer;
  logic                drop_now;
  logic [ID_WIDTH-1:0] rd_addr;

  assign rdy    = !out_vld_reg || user_out_rdy_i;
  assign accept = user_in_tvld_i && rdy;
  assign xfer   = rdy && s1_vld_reg;
  // a stalled stage 1 keeps re-reading its own channel so the lookup stays aligned
  assign rd_addr  = (s1_vld_reg && !rdy) ? s1_tid_reg : user_in_tid_i;
  // SOP beats decide the drop from the freshly read enable; later beats inherit it
  assign drop_now = s1_sop_reg ? !en_q_reg : drop_reg;

  // per-channel enable write decode
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_en_sel
      assign en_wr_sel[gi] = cntrl_cell_dest_wr_i[3] && (cntrl_addr_cell_dest_i == ID_WIDTH'(gi));
    end
  endgenerate

  // table RAM writes
  always_ff @(posedge clk) begin
    if (cntrl_cell_dest_wr_i[0]) mac_ram[cntrl_addr_cell_dest_i]  <= cntrl_mac_dest_i;
    if (cntrl_cell_dest_wr_i[1]) ip_ram[cntrl_addr_cell_dest_i]   <= cntrl_ip_dest_i;
    if (cntrl_cell_dest_wr_i[2]) port_ram[cntrl_addr_cell_dest_i] <= cntrl_port_dest_i;
  end

  // registered read-first RAM reads for the pipeline and for control readback
  always_ff @(posedge clk) begin
    mac_q_reg   <= mac_ram[rd_addr];
    ip_q_reg    <= ip_ram[rd_addr];
    port_q_reg  <= port_ram[rd_addr];
    mac_rd_reg  <= mac_ram[cntrl_addr_cell_dest_i];
    ip_rd_reg   <= ip_ram[cntrl_addr_cell_dest_i];
    port_rd_reg <= port_ram[cntrl_addr_cell_dest_i];
  end

  // enable flop vector and its two registered read ports
  always_ff @(posedge clk) begin
    if (reset) begin
      en_reg    <= '0;
      en_q_reg  <= 1'b0;
      en_rd_reg <= 1'b0;
    end else begin
      en_reg    <= (en_reg & ~en_wr_sel) | (en_wr_sel & {NCH{cntrl_chan_en_i}});
      en_q_reg  <= en_reg[rd_addr];
      en_rd_reg <= en_reg[cntrl_addr_cell_dest_i];
    end
  end

  // SOP tracking on accepted input beats
  always_ff @(posedge clk) begin
    if (reset) begin
      sop_reg <= 1'b1;
    end else if (accept) begin
      sop_reg <= user_in_tlast_i;
    end
  end

  // stage 1 register
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_reg  <= 1'b0;
      s1_sop_reg  <= 1'b0;
      s1_last_reg <= 1'b0;
      s1_tid_reg  <= '0;
      s1_data_reg <= '0;
      s1_keep_reg <= '0;
    end else if (rdy) begin
      s1_vld_reg <= user_in_tvld_i;
      if (user_in_tvld_i) begin
        s1_sop_reg  <= sop_reg;
        s1_last_reg <= user_in_tlast_i;
        s1_tid_reg  <= user_in_tid_i;
        s1_data_reg <= user_in_tdata_i;
        s1_keep_reg <= user_in_tkeep_i;
      end
    end
  end

  // stage 2: output beat, drop flag and header latch
  always_ff @(posedge clk) begin
    if (reset) begin
      out_vld_reg       <= 1'b0;
      out_last_reg      <= 1'b0;
      out_data_reg      <= '0;
      out_keep_reg      <= '0;
      drop_reg          <= 1'b0;
      hdr_mac_dest_reg  <= '0;
      hdr_mac_src_reg   <= '0;
      hdr_ip_dest_reg   <= '0;
      hdr_ip_src_reg    <= '0;
      hdr_port_dest_reg <= '0;
      hdr_port_src_reg  <= '0;
      hdr_tid_reg       <= '0;
    end else if (rdy) begin
      out_vld_reg <= xfer && !drop_now;
      if (xfer) begin
        drop_reg <= drop_now && !s1_last_reg;
        if (!drop_now) begin
          out_last_reg <= s1_last_reg;
          out_data_reg <= s1_data_reg;
          out_keep_reg <= s1_keep_reg;
        end
        if (s1_sop_reg) begin
          hdr_mac_dest_reg  <= mac_q_reg;
          hdr_ip_dest_reg   <= ip_q_reg;
          hdr_port_dest_reg <= port_q_reg;
          hdr_mac_src_reg   <= cntrl_mac_src_i;
          hdr_ip_src_reg    <= cntrl_ip_src_i;
          hdr_port_src_reg  <= cntrl_port_src_i;
          hdr_tid_reg       <= s1_tid_reg;
        end
      end
    end
  end

  // packet statistics; clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (reset || stat_clr_i) begin
      tx_cnt_reg   <= '0;
      drop_cnt_reg <= '0;
    end else begin
      if (out_vld_reg && user_out_rdy_i && out_last_reg) tx_cnt_reg <= tx_cnt_reg + 32'd1;
      if (xfer && s1_sop_reg && !en_q_reg) drop_cnt_reg <= drop_cnt_reg + 32'd1;
    end
  end

  assign user_in_trdy_o          = rdy;
  assign user_out_tvld_o         = out_vld_reg;
  assign user_out_tlast_o        = out_last_reg;
  assign user_out_tdata_o        = out_data_reg;
  assign user_out_tkeep_o        = out_keep_reg;
  assign hdr_mac_dest_o          = hdr_mac_dest_reg;
  assign hdr_mac_src_o           = hdr_mac_src_reg;
  assign hdr_ip_dest_o           = hdr_ip_dest_reg;
  assign hdr_ip_src_o            = hdr_ip_src_reg;
  assign hdr_port_dest_o         = hdr_port_dest_reg;
  assign hdr_port_src_o          = hdr_port_src_reg;
  assign hdr_tid_o               = hdr_tid_reg;
  assign cntrl_mac_dest_rdata_o  = mac_rd_reg;
  assign cntrl_ip_dest_rdata_o   = ip_rd_reg;
  assign cntrl_port_dest_rdata_o = port_rd_reg;
  assign cntrl_chan_en_rdata_o   = en_rd_reg;
  assign stat_tx_pkt_o           = tx_cnt_reg;
  assign stat_drop_pkt_o         = drop_cnt_reg;

endmodule

// File: tb/tb_umstr_chan_packer.sv
// Bench for umstr_chan_packer: a packet-level model (shadow tables, expected
// beat queue, packet counters) checked on every cycle, plus literal pins.
module tb_umstr_chan_packer;

  localparam logic [47:0] SRC_MAC  = 48'h0A0B_0C0D_0E0F;
  localparam logic [31:0] SRC_IP   = 32'hC0A8_0001;
  localparam logic [15:0] SRC_PORT = 16'h1388;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  cntrl_addr_cell_dest_i = '0;
  logic [47:0] cntrl_mac_dest_i = '0;
  logic [31:0] cntrl_ip_dest_i = '0;
  logic [15:0] cntrl_port_dest_i = '0;
  logic        cntrl_chan_en_i = 1'b0;
  logic [3:0]  cntrl_cell_dest_wr_i = '0;
  logic [47:0] cntrl_mac_dest_rdata_o;
  logic [31:0] cntrl_ip_dest_rdata_o;
  logic [15:0] cntrl_port_dest_rdata_o;
  logic        cntrl_chan_en_rdata_o;
  logic        stat_clr_i = 1'b0;
  logic [31:0] stat_tx_pkt_o, stat_drop_pkt_o;
  logic [3:0]  user_in_tid_i = '0;
  logic [31:0] user_in_tdata_i = '0;
  logic [3:0]  user_in_tkeep_i = '0;
  logic        user_in_tvld_i = 1'b0, user_in_tlast_i = 1'b0;
  logic        user_in_trdy_o;
  logic [47:0] hdr_mac_dest_o, hdr_mac_src_o;
  logic [31:0] hdr_ip_dest_o, hdr_ip_src_o;
  logic [15:0] hdr_port_dest_o, hdr_port_src_o;
  logic [3:0]  hdr_tid_o;
  logic [31:0] user_out_tdata_o;
  logic [3:0]  user_out_tkeep_o;
  logic        user_out_tvld_o, user_out_tlast_o;
  logic        user_out_rdy_i;
  logic        rnd_mode = 1'b0, rnd_rdy = 1'b1, fix_rdy = 1'b1;

  assign user_out_rdy_i = rnd_mode ? rnd_rdy : fix_rdy;

  umstr_chan_packer #(.ID_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .cntrl_mac_src_i(SRC_MAC), .cntrl_ip_src_i(SRC_IP), .cntrl_port_src_i(SRC_PORT),
    .cntrl_addr_cell_dest_i(cntrl_addr_cell_dest_i),
    .cntrl_mac_dest_i(cntrl_mac_dest_i), .cntrl_ip_dest_i(cntrl_ip_dest_i),
    .cntrl_port_dest_i(cntrl_port_dest_i), .cntrl_chan_en_i(cntrl_chan_en_i),
    .cntrl_cell_dest_wr_i(cntrl_cell_dest_wr_i),
    .cntrl_mac_dest_rdata_o(cntrl_mac_dest_rdata_o), .cntrl_ip_dest_rdata_o(cntrl_ip_dest_rdata_o),
    .cntrl_port_dest_rdata_o(cntrl_port_dest_rdata_o), .cntrl_chan_en_rdata_o(cntrl_chan_en_rdata_o),
    .stat_clr_i(stat_clr_i), .stat_tx_pkt_o(stat_tx_pkt_o), .stat_drop_pkt_o(stat_drop_pkt_o),
    .user_in_tid_i(user_in_tid_i), .user_in_tdata_i(user_in_tdata_i),
    .user_in_tkeep_i(user_in_tkeep_i), .user_in_tvld_i(user_in_tvld_i),
    .user_in_tlast_i(user_in_tlast_i), .user_in_trdy_o(user_in_trdy_o),
    .hdr_mac_dest_o(hdr_mac_dest_o), .hdr_mac_src_o(hdr_mac_src_o),
    .hdr_ip_dest_o(hdr_ip_dest_o), .hdr_ip_src_o(hdr_ip_src_o),
    .hdr_port_dest_o(hdr_port_dest_o), .hdr_port_src_o(hdr_port_src_o),
    .hdr_tid_o(hdr_tid_o), .user_out_tdata_o(user_out_tdata_o),
    .user_out_tkeep_o(user_out_tkeep_o), .user_out_tvld_o(user_out_tvld_o),
    .user_out_tlast_o(user_out_tlast_o), .user_out_rdy_i(user_out_rdy_i)
  );

  always #5 clk = ~clk;

  // pseudo-random output back-pressure
  always @(posedge clk) begin
    #1;
    rnd_rdy = 1'($urandom_range(0, 1));
  end

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [47:0] mac;
    logic [31:0] ip;
    logic [15:0] port;
    logic [3:0]  tid;
  } beat_t;

  beat_t       exp_q[$];
  logic [47:0] sh_mac  [16];
  logic [31:0] sh_ip   [16];
  logic [15:0] sh_port [16];
  logic [15:0] sh_en;
  bit          m_sop = 1'b1;
  bit          m_en;
  logic [47:0] m_mac;
  logic [31:0] m_ip;
  logic [15:0] m_port;
  logic [3:0]  m_tid;
  int          m_tx = 0, m_drop = 0;
  int          total = 0, bad = 0;
  bit          stall_v = 1'b0;
  logic [36:0] sv_dkl;
  logic [51:0] sv_hdr;
  logic [47:0] sv_mac;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // model update and per-cycle comparison; every decision here concerns the next edge
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_sop = 1'b1;
      sh_en = '0;
      m_tx = 0;
      m_drop = 0;
      stall_v = 1'b0;
    end else begin
      if (stall_v) begin
        chk("stall_vld", 64'(user_out_tvld_o), 64'd1);
        chk("stall_data", 64'({user_out_tdata_o, user_out_tkeep_o, user_out_tlast_o}), 64'(sv_dkl));
        chk("stall_hdr", 64'({hdr_ip_dest_o, hdr_port_dest_o, hdr_tid_o}), 64'(sv_hdr));
        chk("stall_mac", 64'(hdr_mac_dest_o), 64'(sv_mac));
      end
      chk("stat_tx", 64'(stat_tx_pkt_o), 64'(m_tx));
      if (user_out_tvld_o && user_out_rdy_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(exp_q.size()), 64'd1);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("out_data", 64'(user_out_tdata_o), 64'(e.data));
          chk("out_keep", 64'(user_out_tkeep_o), 64'(e.keep));
          chk("out_last", 64'(user_out_tlast_o), 64'(e.last));
          chk("hdr_mac_dest", 64'(hdr_mac_dest_o), 64'(e.mac));
          chk("hdr_ip_dest", 64'(hdr_ip_dest_o), 64'(e.ip));
          chk("hdr_port_dest", 64'(hdr_port_dest_o), 64'(e.port));
          chk("hdr_tid", 64'(hdr_tid_o), 64'(e.tid));
          chk("hdr_src", {hdr_mac_src_o, hdr_port_src_o}, {SRC_MAC, SRC_PORT});
          chk("hdr_ip_src", 64'(hdr_ip_src_o), 64'(SRC_IP));
        end
      end
      stall_v = user_out_tvld_o && !user_out_rdy_i;
      sv_dkl  = {user_out_tdata_o, user_out_tkeep_o, user_out_tlast_o};
      sv_hdr  = {hdr_ip_dest_o, hdr_port_dest_o, hdr_tid_o};
      sv_mac  = hdr_mac_dest_o;
      if (stat_clr_i) begin
        m_tx = 0;
        m_drop = 0;
      end else if (user_out_tvld_o && user_out_rdy_i && user_out_tlast_o) begin
        m_tx++;
      end
      if (user_in_tvld_i && user_in_trdy_o) begin
        if (m_sop) begin
          m_tid  = user_in_tid_i;
          m_en   = sh_en[user_in_tid_i];
          m_mac  = sh_mac[user_in_tid_i];
          m_ip   = sh_ip[user_in_tid_i];
          m_port = sh_port[user_in_tid_i];
          if (!m_en) m_drop++;
        end
        if (m_en) exp_q.push_back('{user_in_tdata_i, user_in_tkeep_i, user_in_tlast_i,
                                    m_mac, m_ip, m_port, m_tid});
        m_sop = user_in_tlast_i;
      end
      if (cntrl_cell_dest_wr_i[0]) sh_mac[cntrl_addr_cell_dest_i]  = cntrl_mac_dest_i;
      if (cntrl_cell_dest_wr_i[1]) sh_ip[cntrl_addr_cell_dest_i]   = cntrl_ip_dest_i;
      if (cntrl_cell_dest_wr_i[2]) sh_port[cntrl_addr_cell_dest_i] = cntrl_port_dest_i;
      if (cntrl_cell_dest_wr_i[3]) sh_en[cntrl_addr_cell_dest_i]   = cntrl_chan_en_i;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [3:0] ch, input logic [47:0] mac, input logic [31:0] ip,
                     input logic [15:0] port, input logic en, input logic [3:0] wr);
    cntrl_addr_cell_dest_i = ch;
    cntrl_mac_dest_i = mac;
    cntrl_ip_dest_i = ip;
    cntrl_port_dest_i = port;
    cntrl_chan_en_i = en;
    cntrl_cell_dest_wr_i = wr;
    tick();
    cntrl_cell_dest_wr_i = '0;
  endtask

  task automatic wait_accept();
    bit ok = 1'b0;
    int n = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = user_in_trdy_o && !reset;
      tick();
      n++;
    end
    if (!ok) chk("accept_timeout", 64'(ok), 64'd1);
  endtask

  task automatic set_beat(input logic [3:0] tid, input logic [15:0] pid, input int b, input bit last);
    user_in_tid_i   = tid;
    user_in_tdata_i = {pid, 8'hA5, 8'(b)};
    user_in_tkeep_i = last ? 4'($urandom_range(1, 15)) : 4'hF;
    user_in_tlast_i = last;
    user_in_tvld_i  = 1'b1;
  endtask

  task automatic send_pkt(input logic [3:0] tid, input int nb, input logic [3:0] alt_tid,
                          input logic [15:0] pid);
    for (int b = 0; b < nb; b++) begin
      set_beat((b == 0) ? tid : alt_tid, pid, b, b == nb - 1);
      wait_accept();
    end
    user_in_tvld_i  = 1'b0;
    user_in_tlast_i = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || user_out_tvld_o) && n < 1000) begin
      tick();
      n++;
    end
    chk(nm, 64'(n < 1000), 64'd1);
    repeat (3) tick();
  endtask

  initial begin
    logic [3:0] chs [4];
    chs = '{4'd3, 4'd6, 4'd9, 4'd12};
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    // reset state
    chk("rst_out_vld", 64'(user_out_tvld_o), 64'd0);
    chk("rst_trdy", 64'(user_in_trdy_o), 64'd1);
    chk("rst_stat_tx", 64'(stat_tx_pkt_o), 64'd0);
    chk("rst_stat_drop", 64'(stat_drop_pkt_o), 64'd0);
    chk("rst_hdr_mac", 64'(hdr_mac_dest_o), 64'd0);
    cntrl_addr_cell_dest_i = 4'd3;
    tick();
    chk("rst_en3", 64'(cntrl_chan_en_rdata_o), 64'd0);

    // configure channels; ch2 ip supplies the old value for the readback test
    cfg(4'd2, 48'h0200_0000_0002, 32'hC0A8_0002, 16'h1F92, 1'b0, 4'b0111);
    cfg(4'd3, 48'h0200_0000_0003, 32'hC0A8_0003, 16'h1F93, 1'b1, 4'b1111);
    tick();

    // 4-beat packet on ch3, 2-cycle latency
    fork
      send_pkt(4'd3, 4, 4'd0, 16'h0001);
      begin
        tick();
        chk("lat_vld_c1", 64'(user_out_tvld_o), 64'd0);
        tick();
        chk("lat_vld_c2", 64'(user_out_tvld_o), 64'd1);
        chk("lat_data0", 64'(user_out_tdata_o), 64'h0001_A500);
        chk("lat_hdr_mac", 64'(hdr_mac_dest_o), 64'h0200_0000_0003);
      end
    join
    drain("drain_t1");
    chk("t1_tx", 64'(stat_tx_pkt_o), 64'd1);
    chk("t1_ip", 64'(hdr_ip_dest_o), 64'hC0A8_0003);
    chk("t1_port", 64'(hdr_port_dest_o), 64'h1F93);

    // ch5 never enabled: consumed and dropped
    send_pkt(4'd5, 3, 4'd5, 16'h0002);
    drain("drain_t2");
    chk("t2_drop", 64'(stat_drop_pkt_o), 64'd1);
    chk("t2_tx", 64'(stat_tx_pkt_o), 64'd1);

    // tid changes mid-packet and ch3 mac rewritten after SOP
    cfg(4'd7, 48'h0200_0000_0007, 32'hC0A8_0007, 16'h1F97, 1'b1, 4'b1111);
    fork
      send_pkt(4'd3, 3, 4'd7, 16'h0003);
      begin
        tick();
        cfg(4'd3, 48'h0200_0000_00AA, 32'h0, 16'h0, 1'b0, 4'b0001);
      end
    join
    drain("drain_t3");
    chk("t3_hdr_mac", 64'(hdr_mac_dest_o), 64'h0200_0000_0003);
    chk("t3_hdr_tid", 64'(hdr_tid_o), 64'd3);
    chk("t3_mac_rb", 64'(cntrl_mac_dest_rdata_o), 64'h0200_0000_00AA);
    chk("t3_tx", 64'(stat_tx_pkt_o), 64'd2);

    // 100 back-to-back packets over 4 channels with random back-pressure
    cfg(4'd6, 48'h0200_0000_0006, 32'hC0A8_0006, 16'h1F96, 1'b1, 4'b1111);
    cfg(4'd9, 48'h0200_0000_0009, 32'hC0A8_0009, 16'h1F99, 1'b1, 4'b1111);
    rnd_mode = 1'b1;
    for (int p = 0; p < 100; p++) begin
      send_pkt(chs[$urandom_range(0, 3)], $urandom_range(1, 4), 4'($urandom_range(0, 15)),
               16'(16'h0100 + p));
    end
    rnd_mode = 1'b0;
    drain("drain_t4");
    chk("t4_drop", 64'(stat_drop_pkt_o), 64'(m_drop));

    // reset on beat 2 of a 5-beat ch3 packet, then a 1-beat ch3 packet
    set_beat(4'd3, 16'h0200, 0, 1'b0);
    wait_accept();
    set_beat(4'd9, 16'h0200, 1, 1'b0);
    wait_accept();
    set_beat(4'd9, 16'h0200, 2, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    user_in_tvld_i  = 1'b0;
    user_in_tlast_i = 1'b0;
    chk("t5_out_vld", 64'(user_out_tvld_o), 64'd0);
    chk("t5_hdr_mac", 64'(hdr_mac_dest_o), 64'd0);
    tick();
    send_pkt(4'd3, 1, 4'd3, 16'h0201);
    drain("drain_t5");
    chk("t5_drop", 64'(stat_drop_pkt_o), 64'd1);
    chk("t5_tx", 64'(stat_tx_pkt_o), 64'd0);

    // same-cycle write and readback of ch2 ip
    cfg(4'd2, 48'h0, 32'h0A00_0002, 16'h0, 1'b0, 4'b0010);
    chk("rb_old", 64'(cntrl_ip_dest_rdata_o), 64'hC0A8_0002);
    tick();
    chk("rb_new", 64'(cntrl_ip_dest_rdata_o), 64'h0A00_0002);

    // stat clear coinciding with a tlast handshake
    cfg(4'd3, 48'h0, 32'h0, 16'h0, 1'b1, 4'b1000);
    send_pkt(4'd3, 1, 4'd3, 16'h0300);
    drain("drain_t6a");
    chk("t6_tx_pre", 64'(stat_tx_pkt_o), 64'd1);
    fork
      send_pkt(4'd3, 1, 4'd3, 16'h0301);
      begin
        tick();
        tick();
        chk("t6_tlast_hs", 64'(user_out_tvld_o && user_out_tlast_o && user_out_rdy_i), 64'd1);
        stat_clr_i = 1'b1;
        tick();
        stat_clr_i = 1'b0;
      end
    join
    drain("drain_t6b");
    chk("t6_tx_clr", 64'(stat_tx_pkt_o), 64'd0);
    chk("t6_drop_clr", 64'(stat_drop_pkt_o), 64'd0);
    send_pkt(4'd3, 2, 4'd1, 16'h0302);
    drain("drain_t6c");
    chk("t6_tx_post", 64'(stat_tx_pkt_o), 64'd1);
    chk("t6_hdr_mac", 64'(hdr_mac_dest_o), 64'h0200_0000_00AA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
